osc_freq_meter: RTL and testbench

//  Gated frequency meter downstream of the oscillator counter. Samples one oscillator-derived
//  tap (osc_in, asynchronous to clk) and counts its rising edges over a fixed window of clk cycles.

---
 rtl/osc_meter_pkg.sv | 16 +
 rtl/osc_edge_sync.sv | 46 ++++
 rtl/osc_freq_meter.sv | 149 ++++++++++++++
 tb/tb_osc_freq_meter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_meter_pkg.sv
// Shared definitions for the oscillator frequency meter.
//   meter_state_e   : measurement FSM states
//   DEF_*           : default build parameters for the meter top level
package osc_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2
  } meter_state_e;

  localparam int unsigned DEF_GATE_CYCLES = 1000000;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/osc_edge_sync.sv
// Synchroniser and rising-edge detector for one asynchronous oscillator tap.
// Ports:
//   clk      in  system clock
//   n_rst    in  asynchronous active-high reset
//   osc_in   in  asynchronous oscillator tap
//   load     in  preload the delayed sample with the current synchronised level
//   run      in  track the synchronised level every cycle (measurement in progress)
//   edge_det out rising edge of the synchronised tap in this cycle
module osc_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic osc_in,
  input  logic load,
  input  logic run,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_d_q, s_d_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // The delayed sample is frozen while idle so that it can go stale; the
  // load pulse before a window refreshes it, so a level already high when a
  // measurement starts is never mistaken for an edge.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], osc_in};
    s_d_d  = (load || run) ? s : s_d_q;
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      s_d_q  <= s_d_d;
    end
  end

  assign edge_det = s & ~s_d_q;

endmodule

// File: rtl/osc_freq_meter.sv
// Gated frequency meter: counts rising edges of an asynchronous oscillator
// tap over back-to-back windows of GATE_CYCLES clk cycles and publishes one
// saturating count per window on a valid/ready interface.
// Ports:
//   clk         in  system reference clock
//   n_rst       in  asynchronous active-high reset
//   enable      in  run measurements; low aborts the current window
//   osc_in      in  asynchronous oscillator tap
//   freq_count  out edges counted in the last completed window
//   freq_ovf    out count saturated during that window
//   freq_lost   out previous unread result was overwritten by this one
//   freq_valid  out result held, awaiting freq_ready
//   freq_ready  in  consumer accepts the result when valid & ready
//   busy        out a window is in progress
module osc_freq_meter
  import osc_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             enable,
  input  logic             osc_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_ovf,
  output logic             freq_lost,
  output logic             freq_valid,
  input  logic             freq_ready,
  output logic             busy
);

  localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  meter_state_e      state_q, state_d;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic              ovf_w_q, ovf_w_d;
  logic [CNT_W-1:0]  freq_count_q, freq_count_d;
  logic              freq_ovf_q, freq_ovf_d;
  logic              freq_lost_q, freq_lost_d;
  logic              freq_valid_q, freq_valid_d;

  logic             edge_det;
  logic             cnt_sat;
  logic [CNT_W-1:0] win_cnt;
  logic             win_ovf;
  logic             res_load;
  logic             accept;

  osc_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .n_rst   (n_rst),
    .osc_in  (osc_in),
    .load    (state_q == ARM),
    .run     (state_q == GATE),
    .edge_det(edge_det)
  );

  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    ovf_w_d      = ovf_w_q;
    freq_count_d = freq_count_q;
    freq_ovf_d   = freq_ovf_q;
    freq_lost_d  = freq_lost_q;
    freq_valid_d = freq_valid_q;
    res_load     = 1'b0;

    // Running totals including this cycle's edge, so an edge on the last
    // gate cycle lands in the result of the window it belongs to.
    cnt_sat = (edge_cnt_q == CNT_MAX);
    win_cnt = (edge_det && !cnt_sat) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
    win_ovf = ovf_w_q | (edge_det & cnt_sat);

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = ARM;
      end
      ARM: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        ovf_w_d    = 1'b0;
        state_d    = enable ? GATE : IDLE;
      end
      GATE: begin
        if (!enable) begin
          // Abort wins even on the last cycle: partial windows never publish.
          state_d = IDLE;
        end else if (gate_cnt_q == GATE_LAST) begin
          res_load   = 1'b1;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_w_d    = 1'b0;
        end else begin
          gate_cnt_d = gate_cnt_q + GATE_W'(1);
          edge_cnt_d = win_cnt;
          ovf_w_d    = win_ovf;
        end
      end
      default: state_d = IDLE;
    endcase

    accept = freq_valid_q & freq_ready;
    if (res_load) begin
      freq_count_d = win_cnt;
      freq_ovf_d   = win_ovf;
      freq_lost_d  = freq_valid_q & ~accept;
      freq_valid_d = 1'b1;
    end else if (accept) begin
      freq_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q      <= IDLE;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      ovf_w_q      <= 1'b0;
      freq_count_q <= '0;
      freq_ovf_q   <= 1'b0;
      freq_lost_q  <= 1'b0;
      freq_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      ovf_w_q      <= ovf_w_d;
      freq_count_q <= freq_count_d;
      freq_ovf_q   <= freq_ovf_d;
      freq_lost_q  <= freq_lost_d;
      freq_valid_q <= freq_valid_d;
    end
  end

  assign freq_count = freq_count_q;
  assign freq_ovf   = freq_ovf_q;
  assign freq_lost  = freq_lost_q;
  assign freq_valid = freq_valid_q;
  assign busy       = (state_q == GATE);

endmodule

// File: tb/tb_osc_freq_meter.sv
`timescale 1ns/1ps
// Bench for osc_freq_meter with 100-cycle windows. Two instances: an 8-bit
// counter build (a) and a 4-bit build (b) for saturation. Oscillator taps are
// generated with their own delays, offset from the clk edges.
module tb_osc_freq_meter;

  typedef struct {
    int cnt;
    bit ovf;
    bit lost;
    int tol;
  } exp_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;

  logic       enable_a = 1'b0, osc_a, ready_a = 1'b0;
  logic [7:0] count_a;
  logic       ovf_a, lost_a, valid_a, busy_a;

  logic       enable_b = 1'b0, osc_b, ready_b = 1'b0;
  logic [3:0] count_b;
  logic       ovf_b, lost_b, valid_b, busy_b;

  int   osc_a_half = 50, osc_b_half = 50;
  bit   osc_a_run = 1'b0, osc_b_run = 1'b0;
  logic osc_a_lvl = 1'b0, osc_b_lvl = 1'b0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  osc_freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .n_rst(n_rst), .enable(enable_a), .osc_in(osc_a),
    .freq_count(count_a), .freq_ovf(ovf_a), .freq_lost(lost_a),
    .freq_valid(valid_a), .freq_ready(ready_a), .busy(busy_a)
  );

  osc_freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .n_rst(n_rst), .enable(enable_b), .osc_in(osc_b),
    .freq_count(count_b), .freq_ovf(ovf_b), .freq_lost(lost_b),
    .freq_valid(valid_b), .freq_ready(ready_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Free-running toggle with a programmable half period, or a held level.
  initial begin : gen_osc_a
    osc_a = 1'b0;
    forever begin
      if (osc_a_run) begin
        #(osc_a_half);
        if (osc_a_run) osc_a = ~osc_a;
      end else begin
        osc_a = osc_a_lvl;
        #1;
      end
    end
  end

  initial begin : gen_osc_b
    osc_b = 1'b0;
    forever begin
      if (osc_b_run) begin
        #(osc_b_half);
        if (osc_b_run) osc_b = ~osc_b;
      end else begin
        osc_b = osc_b_lvl;
        #1;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid_a(input int budget, output int waited);
    waited = 0;
    while (valid_a !== 1'b1 && waited < budget) begin
      tick(1);
      waited++;
    end
  endtask

  task automatic wait_valid_b(input int budget, output int waited);
    waited = 0;
    while (valid_b !== 1'b1 && waited < budget) begin
      tick(1);
      waited++;
    end
  endtask

  task automatic pop_cmp_a(input string tag);
    exp_t e;
    int   got;
    checks++;
    if (sb_a.size() == 0) begin
      errors++;
      $display("FAIL %s sb_empty: got result with no expectation queued", tag);
      return;
    end
    e   = sb_a.pop_front();
    got = int'(count_a);
    $display("txn a %s: count=%0d ovf=%b lost=%b valid=%b (exp %0d+/-%0d ovf=%b lost=%b)",
             tag, got, ovf_a, lost_a, valid_a, e.cnt, e.tol, e.ovf, e.lost);
    if (got < e.cnt - e.tol || got > e.cnt + e.tol) begin
      errors++;
      $display("FAIL %s count: got %0d want %0d+/-%0d", tag, got, e.cnt, e.tol);
    end
    checks++;
    if (ovf_a !== e.ovf) begin
      errors++;
      $display("FAIL %s ovf: got %b want %b", tag, ovf_a, e.ovf);
    end
    checks++;
    if (lost_a !== e.lost) begin
      errors++;
      $display("FAIL %s lost: got %b want %b", tag, lost_a, e.lost);
    end
  endtask

  task automatic pop_cmp_b(input string tag);
    exp_t e;
    int   got;
    checks++;
    if (sb_b.size() == 0) begin
      errors++;
      $display("FAIL %s sb_empty: got result with no expectation queued", tag);
      return;
    end
    e   = sb_b.pop_front();
    got = int'(count_b);
    $display("txn b %s: count=%0d ovf=%b lost=%b valid=%b (exp %0d+/-%0d ovf=%b lost=%b)",
             tag, got, ovf_b, lost_b, valid_b, e.cnt, e.tol, e.ovf, e.lost);
    if (got < e.cnt - e.tol || got > e.cnt + e.tol) begin
      errors++;
      $display("FAIL %s count: got %0d want %0d+/-%0d", tag, got, e.cnt, e.tol);
    end
    checks++;
    if (ovf_b !== e.ovf) begin
      errors++;
      $display("FAIL %s ovf: got %b want %b", tag, ovf_b, e.ovf);
    end
    checks++;
    if (lost_b !== e.lost) begin
      errors++;
      $display("FAIL %s lost: got %b want %b", tag, lost_b, e.lost);
    end
  endtask

  task automatic test_reset();
    n_rst    = 1'b1;
    enable_a = 1'b1;
    tick(3);
    checks++; if (count_a !== 8'd0) begin errors++; $display("FAIL reset count: got %0d want 0", count_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset ovf: got %b want 0", ovf_a); end
    checks++; if (lost_a !== 1'b0) begin errors++; $display("FAIL reset lost: got %b want 0", lost_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", valid_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy_a); end
    checks++; if (valid_b !== 1'b0 || count_b !== 4'd0) begin errors++; $display("FAIL reset b: got valid=%b count=%0d want 0/0", valid_b, count_b); end
    enable_a = 1'b0;
    n_rst    = 1'b0;
    tick(2);
    $display("txn reset: released");
  endtask

  task automatic test_steady();
    int w, want;
    osc_a_half = 50; osc_a_run = 1'b1; ready_a = 1'b1;
    tick(5);
    repeat (3) sb_a.push_back('{cnt: 10, ovf: 1'b0, lost: 1'b0, tol: 1});
    enable_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid_a(120, w);
      want = (k == 0) ? 102 : 99;
      checks++; if (w !== want) begin errors++; $display("FAIL steady latency[%0d]: got %0d cycles want %0d", k, w, want); end
      pop_cmp_a($sformatf("steady[%0d]", k));
      tick(1);
      checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL steady accept[%0d]: valid got %b want 0", k, valid_a); end
    end
    enable_a = 1'b0;
    tick(2);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL steady stop busy: got %b want 0", busy_a); end
    osc_a_run = 1'b0; osc_a_lvl = 1'b0;
    tick(2);
  endtask

  task automatic test_no_false_edge();
    int w;
    n_rst = 1'b1; osc_a_lvl = 1'b1;
    tick(3);
    n_rst = 1'b0;
    tick(5);
    sb_a.push_back('{cnt: 0, ovf: 1'b0, lost: 1'b0, tol: 0});
    ready_a = 1'b1; enable_a = 1'b1;
    wait_valid_a(120, w);
    checks++; if (w !== 102) begin errors++; $display("FAIL nofalse latency: got %0d want 102", w); end
    pop_cmp_a("nofalse");
    tick(1);
    enable_a = 1'b0;
    tick(2);
  endtask

  task automatic test_saturate();
    int w;
    osc_b_half = 20; osc_b_run = 1'b1; ready_b = 1'b1;
    tick(5);
    sb_b.push_back('{cnt: 15, ovf: 1'b1, lost: 1'b0, tol: 0});
    sb_b.push_back('{cnt: 10, ovf: 1'b0, lost: 1'b0, tol: 1});
    enable_b = 1'b1;
    tick(97);
    osc_b_half = 50;
    wait_valid_b(20, w);
    checks++; if (w !== 5) begin errors++; $display("FAIL sat latency: got %0d want 5", w); end
    pop_cmp_b("sat");
    tick(1);
    wait_valid_b(120, w);
    checks++; if (w !== 99) begin errors++; $display("FAIL sat next latency: got %0d want 99", w); end
    pop_cmp_b("sat_next");
    enable_b = 1'b0; osc_b_run = 1'b0;
    tick(2);
  endtask

  task automatic test_lost();
    int w;
    osc_a_lvl = 1'b0; osc_a_half = 50; osc_a_run = 1'b1; ready_a = 1'b0;
    tick(5);
    sb_a.push_back('{cnt: 15, ovf: 1'b0, lost: 1'b0, tol: 2});
    sb_a.push_back('{cnt: 20, ovf: 1'b0, lost: 1'b1, tol: 1});
    enable_a = 1'b1;
    tick(52);
    osc_a_half = 25;
    wait_valid_a(60, w);
    checks++; if (w !== 50) begin errors++; $display("FAIL lost latency: got %0d want 50", w); end
    pop_cmp_a("lost_first");
    tick(99);
    checks++; if (valid_a !== 1'b1 || lost_a !== 1'b0) begin errors++; $display("FAIL lost hold: got valid=%b lost=%b want 1/0", valid_a, lost_a); end
    tick(1);
    checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL lost overwrite valid: got %b want 1", valid_a); end
    pop_cmp_a("lost_second");
    ready_a = 1'b1;
    tick(1);
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL lost accept: valid got %b want 0", valid_a); end
    enable_a = 1'b0; osc_a_run = 1'b0;
    tick(2);
  endtask

  task automatic test_abort();
    int w;
    osc_a_half = 50; osc_a_run = 1'b1; ready_a = 1'b0;
    tick(5);
    sb_a.push_back('{cnt: 10, ovf: 1'b0, lost: 1'b0, tol: 1});
    enable_a = 1'b1;
    wait_valid_a(120, w);
    checks++; if (w !== 102) begin errors++; $display("FAIL abort latency: got %0d want 102", w); end
    pop_cmp_a("abort_held");
    tick(50);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL abort busy before: got %b want 1", busy_a); end
    enable_a = 1'b0;
    tick(1);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort busy after: got %b want 0", busy_a); end
    tick(110);
    checks++; if (valid_a !== 1'b1 || lost_a !== 1'b0) begin errors++; $display("FAIL abort kept: got valid=%b lost=%b want 1/0", valid_a, lost_a); end
    checks++; if (count_a < 8'd9 || count_a > 8'd11) begin errors++; $display("FAIL abort count kept: got %0d want 10+/-1", count_a); end
    ready_a = 1'b1;
    tick(1);
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL abort accept: valid got %b want 0", valid_a); end
    sb_a.push_back('{cnt: 10, ovf: 1'b0, lost: 1'b0, tol: 1});
    enable_a = 1'b1;
    wait_valid_a(120, w);
    checks++; if (w !== 102) begin errors++; $display("FAIL abort reenable latency: got %0d want 102", w); end
    pop_cmp_a("abort_reenable");
    enable_a = 1'b0; osc_a_run = 1'b0; osc_a_lvl = 1'b0;
    tick(3);
  endtask

  task automatic test_last_edge_and_reset();
    int w;
    osc_a_run = 1'b0; osc_a_lvl = 1'b0; ready_a = 1'b1;
    tick(5);
    sb_a.push_back('{cnt: 1, ovf: 1'b0, lost: 1'b0, tol: 0});
    sb_a.push_back('{cnt: 0, ovf: 1'b0, lost: 1'b0, tol: 0});
    sb_a.push_back('{cnt: 1, ovf: 1'b0, lost: 1'b0, tol: 0});
    enable_a = 1'b1;
    // Rising edge timed so that after synchronisation it falls on gate cycle 99.
    tick(99);
    osc_a_lvl = 1'b1;
    wait_valid_a(10, w);
    checks++; if (w !== 3) begin errors++; $display("FAIL lastedge latency: got %0d want 3", w); end
    pop_cmp_a("lastedge_win");
    tick(1);
    wait_valid_a(120, w);
    checks++; if (w !== 99) begin errors++; $display("FAIL lastedge next latency: got %0d want 99", w); end
    pop_cmp_a("lastedge_next");
    tick(1);
    ready_a = 1'b0;
    tick(20);
    osc_a_lvl = 1'b0;
    tick(20);
    osc_a_lvl = 1'b1;
    wait_valid_a(80, w);
    checks++; if (w !== 59) begin errors++; $display("FAIL rst_setup latency: got %0d want 59", w); end
    pop_cmp_a("rst_setup");
    tick(30);
    checks++; if (busy_a !== 1'b1 || valid_a !== 1'b1) begin errors++; $display("FAIL rst pre: got busy=%b valid=%b want 1/1", busy_a, valid_a); end
    enable_a = 1'b0;
    n_rst    = 1'b1;
    #1;
    checks++; if (count_a !== 8'd0) begin errors++; $display("FAIL rst async count: got %0d want 0", count_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rst async valid: got %b want 0", valid_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst async busy: got %b want 0", busy_a); end
    checks++; if (ovf_a !== 1'b0 || lost_a !== 1'b0) begin errors++; $display("FAIL rst async flags: got ovf=%b lost=%b want 0/0", ovf_a, lost_a); end
    tick(2);
    n_rst = 1'b0;
    tick(2);
    checks++; if (busy_a !== 1'b0 || valid_a !== 1'b0) begin errors++; $display("FAIL rst release: got busy=%b valid=%b want 0/0", busy_a, valid_a); end
    $display("txn reset mid-gate: outputs cleared");
  endtask

  initial begin : main
    test_reset();
    test_steady();
    test_no_false_edge();
    test_saturate();
    test_lost();
    test_abort();
    test_last_edge_and_reset();
    checks++;
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d/%0d expectations pending want 0/0", sb_a.size(), sb_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
